// File: rtl/tape_rec.sv
// tape_rec: cassette recorder capture path.
// Demodulates the CPU cassette output bit into bytes (start bit 0, 8 data bits
// LSB-first, two stop bits of 1) and writes them sequentially into a 64KB
// buffer for upload. The bit value comes from the full-cycle period between
// rising edges of the cassette signal, measured in ce_tape ticks.
// Optional build macro TAPE_REC_CKSUM_EN adds an 8-bit running byte checksum.
module tape_rec #(
  parameter int CNT_W     = 12,
  parameter int SHORT_MAX = 60,
  parameter int LONG_MAX  = 140,
  parameter int GAP_TICKS = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_tape,
  input  logic        cass,
  input  logic        clear,
  output logic [15:0] addr,
  output logic [7:0]  data,
  output logic        we,
  output logic [16:0] length,
  output logic        active,
  output logic        done,
  output logic        frame_err,
  output logic        overflow
`ifdef TAPE_REC_CKSUM_EN
  ,
  output logic [7:0]  cksum
`endif
);

  // Framer states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_STOP1 = 2'd2;
  localparam logic [1:0] ST_STOP2 = 2'd3;

  // Period thresholds sized to the counter
  localparam logic [CNT_W-1:0] SHORT_C = CNT_W'(SHORT_MAX);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_MAX);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'(GAP_TICKS - 1);

  // Input sampling
  logic             s1_q, s2_q, prev_q;
  logic [CNT_W-1:0] cnt_q;

  // Framer
  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh_q, sh_d;
  logic       byte_ok, ferr_set;

  // Write side
  logic [15:0] addr_q;
  logic [7:0]  data_q;
  logic        we_q;
  logic [16:0] length_q;
  logic        active_q, done_q, ferr_q, ovf_q;

  // Decoded per-tick events
  logic edge_w, sat_w, bit_vld, bit_val, gap_w, silence_w, full_w;

  assign edge_w    = ce_tape & s2_q & ~prev_q;
  assign sat_w     = (cnt_q == GAP_C);
  // Only an edge with a valid (unsaturated) period yields a bit or a gap
  assign bit_vld   = edge_w & ~sat_w & (cnt_q <= LONG_C);
  assign gap_w     = edge_w & ~sat_w & (cnt_q >  LONG_C);
  assign bit_val   = (cnt_q <= SHORT_C);
  // The tick on which the counter first reaches the silence threshold
  assign silence_w = ce_tape & ~edge_w & (cnt_q == GAP_M1);
  assign full_w    = length_q[16];

  // Two-flop synchronizer for the asynchronous cassette level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= cass;
      s2_q <= s1_q;
    end
  end

  // Previous ce sample and period counter; an edge wins over saturation
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
      cnt_q  <= GAP_C;
    end else if (ce_tape) begin
      prev_q <= s2_q;
      if (edge_w)      cnt_q <= '0;
      else if (!sat_w) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Framer next state: bits advance it, gaps and silence drop back to idle
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    byte_ok  = 1'b0;
    ferr_set = 1'b0;
    if (silence_w || gap_w) begin
      state_d = ST_IDLE;
    end else if (bit_vld) begin
      case (state_q)
        ST_IDLE: begin
          // a 1 here is leader or stop filler; a 0 is a start bit
          if (!bit_val) begin
            state_d = ST_DATA;
            idx_d   = 3'd0;
          end
        end
        ST_DATA: begin
          sh_d  = {bit_val, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = ST_STOP1;
        end
        ST_STOP1: begin
          if (bit_val) begin
            state_d = ST_STOP2;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_STOP2: begin
          state_d = ST_IDLE;
          if (bit_val) byte_ok  = 1'b1;
          else         ferr_set = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Framer registers; clear restarts framing from idle
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  // Buffer write strobe and sticky error flags; clear discards a pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= 16'd0;
      data_q <= 8'd0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (clear) begin
      we_q   <= 1'b0;
      addr_q <= 16'd0;
      ferr_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      we_q <= byte_ok & ~full_w;
      if (byte_ok && !full_w) begin
        addr_q <= length_q[15:0];
        data_q <= sh_q;
      end
      if (byte_ok && full_w) ovf_q  <= 1'b1;
      if (ferr_set)          ferr_q <= 1'b1;
    end
  end

  // Byte count, activity and end-of-recording pulse; a write keeps us active
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      length_q <= 17'd0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= silence_w & active_q;
      if (silence_w && active_q) active_q <= 1'b0;
      if (we_q) begin
        length_q <= length_q + 17'd1;
        active_q <= 1'b1;
      end
    end
  end

`ifdef TAPE_REC_CKSUM_EN
  logic [7:0] cksum_q;

  // Modulo-256 sum of written bytes, stepped with the byte count
  always_ff @(posedge clk) begin
    if (reset || clear) cksum_q <= 8'd0;
    else if (we_q)      cksum_q <= cksum_q + data_q;
  end

  assign cksum = cksum_q;
`endif

  assign addr      = addr_q;
  assign data      = data_q;
  assign we        = we_q;
  assign length    = length_q;
  assign active    = active_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_tape_rec.sv
// tb_tape_rec: directed + randomized frames against a frame-level model.
// The model tracks which bytes must land in the buffer (and at what address),
// expected length, error flags, checksum and end-of-recording pulses.
module tb_tape_rec;
  logic        clk = 1'b0;
  logic        reset, ce_tape, cass, clear;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        we;
  logic [16:0] length;
  logic        active, done, frame_err, overflow;
`ifdef TAPE_REC_CKSUM_EN
  logic [7:0]  cksum;
`endif

  tape_rec dut (
    .clk(clk), .reset(reset), .ce_tape(ce_tape), .cass(cass), .clear(clear),
    .addr(addr), .data(data), .we(we), .length(length), .active(active),
    .done(done), .frame_err(frame_err), .overflow(overflow)
`ifdef TAPE_REC_CKSUM_EN
    , .cksum(cksum)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  // model state
  logic [23:0] exp_q[$];
  int          exp_len = 0;
  logic [7:0]  exp_sum = 8'd0;
  logic        exp_ferr = 1'b0, exp_ovf = 1'b0, armed = 1'b0;
  int          exp_done = 0, done_cnt = 0;
  logic [23:0] mon_e;
  bit          rnd = 1'b0;
  logic [7:0]  b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write strobe must match the next expected (addr,data)
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL we_unexpected: observed addr %0h data %0h expected no write", addr, data);
      end else begin
        mon_e = exp_q.pop_front();
        check("we_addr", 32'(addr), 32'(mon_e[23:8]));
        check("we_data", 32'(data), 32'(mon_e[7:0]));
      end
    end
    if (done === 1'b1) done_cnt++;
  end

  // One ce tick (ce every other clk); cass changes only between ticks
  task automatic tick(input logic lvl);
    @(negedge clk);
    cass    = lvl;
    ce_tape = 1'b1;
    @(negedge clk);
    ce_tape = 1'b0;
  endtask

  // One full cassette cycle of p ticks: high half then low half
  task automatic cyc(input int p);
    for (int i = 0; i < p; i++) tick(i < p / 2);
  endtask

  task automatic sbit(input logic v);
    if (!rnd)  cyc(v ? 40 : 100);
    else if (v) cyc(int'($urandom_range(55, 10)));
    else        cyc(int'($urandom_range(130, 70)));
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_len  = 0;
    exp_sum  = 8'd0;
    exp_ferr = 1'b0;
    exp_ovf  = 1'b0;
    armed    = 1'b0;
  endtask

  // kind: 0 good, 1 bad first stop, 2 bad second stop
  task automatic frame(input logic [7:0] v, input int kind, input int nlead);
    for (int i = 0; i < nlead; i++) cyc(40);
    sbit(1'b0);
    for (int i = 0; i < 8; i++) sbit(v[i]);
    sbit(kind != 1);
    sbit(kind != 2);
    if (kind == 0) begin
      if (exp_len < 65536) begin
        exp_q.push_back({exp_len[15:0], v});
        exp_len++;
        exp_sum += v;
        armed = 1'b1;
      end else exp_ovf = 1'b1;
    end else exp_ferr = 1'b1;
  endtask

  // Trailing cycle: its edge delimits the last stop bit
  task automatic tail();
    cyc(40);
  endtask

  task automatic quiet();
    for (int i = 0; i < 1010; i++) tick(1'b0);
    if (armed) begin
      exp_done++;
      armed = 1'b0;
    end
    check("done_count", 32'(done_cnt), 32'(exp_done));
    check("active_idle", 32'(active), 32'd0);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    @(negedge clk);
    check("clr_length", 32'(length), 32'd0);
    check("clr_addr", 32'(addr), 32'd0);
    check("clr_ferr", 32'(frame_err), 32'd0);
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_active", 32'(active), 32'd0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_length"}, 32'(length), 32'(exp_len));
    check({tag, "_ferr"}, 32'(frame_err), 32'(exp_ferr));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
`ifdef TAPE_REC_CKSUM_EN
    check({tag, "_cksum"}, 32'(cksum), 32'(exp_sum));
`endif
  endtask

  initial begin
    reset = 1'b1; ce_tape = 1'b0; cass = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_we", 32'(we), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Leader plus one byte, fixed periods
    frame(8'h5A, 0, 20);
    tail();
    check_state("t1");
    check("t1_active", 32'(active), 32'd1);
    quiet();

    // Back-to-back frames, random periods
    rnd = 1'b1;
    pulse_clear();
    frame(8'h00, 0, 2);
    frame(8'hFF, 0, 2);
    frame(8'h81, 0, 2);
    tail();
    check_state("t2");
    check("t2_len3", 32'(length), 32'd3);
    check("t2_active", 32'(active), 32'd1);
    // clear while active: no done pulse afterwards
    pulse_clear();
    quiet();

    // Bad first stop, then a good frame at addr 0
    frame(8'h33, 1, 2);
    frame(8'h44, 0, 2);
    tail();
    check_state("t3");
    quiet();

    // Gap after 4 data bits, then a normal frame
    pulse_clear();
    b = 8'($urandom);
    cyc(40); cyc(40);
    sbit(1'b0);
    for (int i = 0; i < 4; i++) sbit(b[i]);
    cyc(200);
    frame(8'($urandom), 0, 2);
    tail();
    check_state("t4");
    quiet();

    // Random frames with occasional stop errors
    pulse_clear();
    for (int n = 0; n < 5; n++) frame(8'($urandom), ($urandom_range(3, 0) == 0) ? int'($urandom_range(2, 1)) : 0, 2);
    tail();
    check_state("t5");
    quiet();

    // Reset after 5 data bits
    b = 8'($urandom);
    cyc(40); cyc(40);
    sbit(1'b0);
    for (int i = 0; i < 5; i++) sbit(b[i]);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("mrst_length", 32'(length), 32'd0);
    check("mrst_we", 32'(we), 32'd0);
    check("mrst_addr", 32'(addr), 32'd0);
    check("mrst_active", 32'(active), 32'd0);
    frame(8'($urandom), 0, 2);
    tail();
    check_state("t6");
    quiet();

    // Full buffer: byte dropped, overflow sticky, then clear
    pulse_clear();
    force dut.length_q = 17'h10000;
    exp_len = 65536;
    frame(8'h12, 0, 2);
    tail();
    repeat (4) @(negedge clk);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_length", 32'(length), 32'h10000);
    check("ovf_active", 32'(active), 32'd0);
    release dut.length_q;
    pulse_clear();
    quiet();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
